// File: rtl/tile_judge_if.sv
// Bundles the game-controller and playfield signals seen by the tile judge.
// The master side drives the inputs; the judge itself uses the slave modport.
interface tile_judge_if;
    logic       enable;
    logic       tick;
    logic [3:0] keys;
    logic [3:0] bottom_lane;
    logic       increment;
    logic       miss;
    logic       game_over;
    logic [7:0] combo;
    logic [1:0] lives;

    modport master (
        output enable, tick, keys, bottom_lane,
        input  increment, miss, game_over, combo, lives
    );

    modport slave (
        input  enable, tick, keys, bottom_lane,
        output increment, miss, game_over, combo, lives
    );
endinterface

// File: rtl/tile_judge.sv
// Rhythm-game judge: debounces four lane buttons and scores hits and misses
// against the tile currently sitting in the judge row.
module tile_judge #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [1:0]  LIVES           = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    tile_judge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, WAIT, OVER} state_e;

    logic [3:0]       syncMeta_q;
    logic [3:0]       syncOut_q;
    logic [3:0]       pressedLevel;
    logic [3:0]       debounced_q;
    logic [3:0]       debounced_d;
    logic [3:0]       debouncedPrev_q;
    logic [3:0][15:0] debounceCnt_q;
    logic [3:0][15:0] debounceCnt_d;
    logic [3:0]       press;

    state_e     state_q;
    logic [3:0] target_q;
    logic       increment_q;
    logic       miss_q;
    logic       gameOver_q;
    logic [7:0] combo_q;
    logic [1:0] lives_q;

    logic hit;
    logic wrongPress;
    logic tilePassed;
    logic missEvent;

    // Buttons are active-low, so the synchronizer idles high (released).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncMeta_q <= 4'hF;
            syncOut_q  <= 4'hF;
        end else begin
            syncMeta_q <= bus.keys;
            syncOut_q  <= syncMeta_q;
        end
    end

    assign pressedLevel = ~syncOut_q;

    always_comb begin
        debounced_d   = debounced_q;
        debounceCnt_d = debounceCnt_q;
        for (int i = 0; i < 4; i++) begin
            if (pressedLevel[i] != debounced_q[i]) begin
                if (debounceCnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    debounced_d[i]   = pressedLevel[i];
                    debounceCnt_d[i] = 16'd0;
                end else begin
                    debounceCnt_d[i] = debounceCnt_q[i] + 16'd1;
                end
            end else begin
                debounceCnt_d[i] = 16'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debounced_q     <= 4'h0;
            debouncedPrev_q <= 4'h0;
            debounceCnt_q   <= '0;
        end else begin
            debounced_q     <= debounced_d;
            debouncedPrev_q <= debounced_q;
            debounceCnt_q   <= debounceCnt_d;
        end
    end

    assign press = debounced_q & ~debouncedPrev_q;

    // A press is judged against the held target before a same-cycle tick replaces it.
    assign hit        = (state_q == WAIT) && (target_q != 4'h0) && (press == target_q);
    assign wrongPress = (press != 4'h0) && !hit;
    assign tilePassed = (state_q == WAIT) && bus.tick && !hit;
    assign missEvent  = wrongPress || tilePassed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= 4'h0;
            increment_q <= 1'b0;
            miss_q      <= 1'b0;
            gameOver_q  <= 1'b0;
            combo_q     <= 8'd0;
            lives_q     <= 2'd0;
        end else begin
            increment_q <= 1'b0;
            miss_q      <= 1'b0;
            if (!bus.enable) begin
                state_q    <= IDLE;
                gameOver_q <= 1'b0;
                target_q   <= 4'h0;
            end else begin
                case (state_q)
                    IDLE: begin
                        lives_q  <= LIVES;
                        combo_q  <= 8'd0;
                        target_q <= 4'h0;
                        state_q  <= ARMED;
                    end
                    ARMED, WAIT: begin
                        if (hit) begin
                            increment_q <= 1'b1;
                            if (combo_q != 8'hFF) begin
                                combo_q <= combo_q + 8'd1;
                            end
                        end
                        if (bus.tick) begin
                            target_q <= bus.bottom_lane;
                            state_q  <= (bus.bottom_lane != 4'h0) ? WAIT : ARMED;
                        end else if (hit) begin
                            target_q <= 4'h0;
                            state_q  <= ARMED;
                        end
                        // Two coinciding miss causes still cost only one life.
                        if (missEvent) begin
                            miss_q  <= 1'b1;
                            combo_q <= 8'd0;
                            lives_q <= lives_q - 2'd1;
                            if (lives_q == 2'd1) begin
                                state_q    <= OVER;
                                gameOver_q <= 1'b1;
                            end
                        end
                    end
                    OVER: begin
                        gameOver_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.increment = increment_q;
    assign bus.miss      = miss_q;
    assign bus.game_over = gameOver_q;
    assign bus.combo     = combo_q;
    assign bus.lives     = lives_q;
endmodule

// File: tb/tb_tile_judge.sv
// Bench for tile_judge: directed game scenarios plus random play, every cycle
// compared against a lane/rule-level model of the game.
module tb_tile_judge;
    localparam int DB = 4;
    localparam int START_LIVES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectorCount = 0;
    int missCount = 0;

    tile_judge_if bus ();

    tile_judge #(
        .DEBOUNCE_CYCLES(16'd4),
        .LIVES(2'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [3:0] keyDelay[$];
    logic [3:0] lvlHist[$];
    logic [3:0] mDb;
    logic [3:0] pendingPress;
    logic       mActive;
    logic       mOver;
    logic       mInc;
    logic       mMiss;
    int         mTarget;
    int         mCombo;
    int         mLives;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h want %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int laneOf(input logic [3:0] oneHot);
        int idx;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (oneHot[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic modelReset();
        keyDelay = {4'hF, 4'hF};
        lvlHist.delete();
        for (int i = 0; i < DB; i++) lvlHist.push_back(4'h0);
        mDb = 4'h0;
        pendingPress = 4'h0;
        mActive = 1'b0;
        mOver = 1'b0;
        mInc = 1'b0;
        mMiss = 1'b0;
        mTarget = -1;
        mCombo = 0;
        mLives = 0;
    endtask

    // A lane flips once its last DB synchronized samples all disagree with it.
    task automatic modelStep();
        logic [3:0] lvl;
        logic [3:0] p;
        logic [3:0] rose;
        logic agree;
        logic hit;
        logic bad;
        p = pendingPress;
        lvl = ~keyDelay.pop_front();
        keyDelay.push_back(bus.keys);
        lvlHist.push_back(lvl);
        if (lvlHist.size() > DB) void'(lvlHist.pop_front());
        rose = 4'h0;
        for (int lane = 0; lane < 4; lane++) begin
            agree = 1'b0;
            foreach (lvlHist[j]) if (lvlHist[j][lane] == mDb[lane]) agree = 1'b1;
            if (!agree) begin
                rose[lane] = ~mDb[lane];
                mDb[lane] = ~mDb[lane];
            end
        end
        pendingPress = rose;

        mInc = 1'b0;
        mMiss = 1'b0;
        if (!bus.enable) begin
            mActive = 1'b0;
            mOver = 1'b0;
            mTarget = -1;
        end else if (!mActive) begin
            mActive = 1'b1;
            mLives = START_LIVES;
            mCombo = 0;
            mTarget = -1;
        end else if (!mOver) begin
            hit = (mTarget >= 0) && (p == 4'(1 << mTarget));
            bad = ((p != 4'h0) && !hit) || (bus.tick && (mTarget >= 0) && !hit);
            if (hit) begin
                mInc = 1'b1;
                if (mCombo < 255) mCombo++;
                mTarget = -1;
            end
            if (bus.tick) mTarget = laneOf(bus.bottom_lane);
            if (bad) begin
                mMiss = 1'b1;
                mCombo = 0;
                mLives--;
                if (mLives == 0) mOver = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] packOutputs(input logic inc, input logic ms, input logic ov,
                                                input logic [7:0] cb, input logic [1:0] lv);
        return {19'd0, inc, ms, ov, cb, lv};
    endfunction

    task automatic applyStimulus(input logic en, input logic tk, input logic [3:0] k, input logic [3:0] bl);
        bus.enable = en;
        bus.tick = tk;
        bus.keys = k;
        bus.bottom_lane = bl;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("outputs",
                    packOutputs(bus.increment, bus.miss, bus.game_over, bus.combo, bus.lives),
                    packOutputs(mInc, mMiss, mOver, 8'(mCombo), 2'(mLives)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'hF, 4'h0);
    endtask

    task automatic restart();
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0);
    endtask

    task automatic holdKeys(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, k, 4'h0);
    endtask

    task automatic hitLane(input int lane);
        logic [3:0] oneHot;
        oneHot = 4'(1 << lane);
        applyStimulus(1'b1, 1'b1, 4'hF, oneHot);
        holdKeys(~oneHot, 6);
        idle(8);
    endtask

    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("resetImmediate",
                    packOutputs(bus.increment, bus.miss, bus.game_over, bus.combo, bus.lives), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic randomPhase(input int cycles);
        logic [3:0] k;
        logic [3:0] bl;
        logic en;
        logic tk;
        int hold[4];
        k = 4'hF;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (hold[lane] == 0) begin
                    k[lane] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                    hold[lane] = $urandom_range(1, 10);
                end
                hold[lane]--;
            end
            en = !(mOver || ($urandom_range(0, 199) == 0));
            tk = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0: bl = 4'h0;
                1: bl = 4'h1;
                2: bl = 4'h2;
                3: bl = 4'h4;
                default: bl = 4'h8;
            endcase
            applyStimulus(en, tk, k, bl);
            if ($urandom_range(0, 799) == 0) doReset();
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.tick = 1'b0;
        bus.keys = 4'hF;
        bus.bottom_lane = 4'h0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetState",
                    packOutputs(bus.increment, bus.miss, bus.game_over, bus.combo, bus.lives), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0);
        checkOutput("startLives", 32'(bus.lives), 32'd3);
        hitLane(2);
        checkOutput("firstHitCombo", 32'(bus.combo), 32'd1);

        // Bouncing lane 1 never settles, so nothing is judged.
        holdKeys(4'b1101, 3);
        holdKeys(4'hF, 1);
        holdKeys(4'b1101, 3);
        idle(8);

        // Hit on lane 0 lands in the same cycle as a tick bringing lane 3.
        applyStimulus(1'b1, 1'b1, 4'hF, 4'b0001);
        holdKeys(4'b1110, 6);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'b1000);
        checkOutput("coincideInc", 32'(bus.increment), 32'd1);
        checkOutput("coincideMiss", 32'(bus.miss), 32'd0);
        idle(8);

        restart();
        applyStimulus(1'b1, 1'b1, 4'hF, 4'b0001);
        idle(2);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'b0010);
        idle(2);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'b0100);
        holdKeys(4'b1110, 6);
        idle(8);
        checkOutput("overLevel", 32'(bus.game_over), 32'd1);
        checkOutput("overLives", 32'(bus.lives), 32'd0);
        checkOutput("overCombo", 32'(bus.combo), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'hF, 4'b0100);
        holdKeys(4'b0111, 6);
        idle(4);

        restart();
        for (int i = 0; i < 257; i++) hitLane(i % 4);
        checkOutput("comboSat", 32'(bus.combo), 32'd255);
        checkOutput("comboLives", 32'(bus.lives), 32'd3);

        applyStimulus(1'b1, 1'b1, 4'hF, 4'b0100);
        holdKeys(4'b1011, 3);
        doReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0);
        checkOutput("restartLives", 32'(bus.lives), 32'd3);
        idle(10);

        randomPhase(4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/tile_judge.md
TILE_JUDGE -- requirements
Module: tile_judge

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning the number of consecutive stable samples needed before a key change is accepted (range 1..65535).
REQ-002 SHALL have parameter LIVES, default 2'd3, meaning the lives loaded at game start (range 1..3).
REQ-003 clock  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  game running; level signal from the game controller.
REQ-006 tick  in  1  one-cycle row-advance strobe; the tile row shifts into the judge row.
REQ-007 keys  in  4  raw pushbuttons, active-low; keys[i] is lane i.
REQ-008 bottom_lane  in  4  one-hot lane of the tile in the judge row; 4'b0000 means no tile.
REQ-009 increment  out  1  one-cycle hit pulse; drives the score register increment input.
REQ-010 miss  out  1  one-cycle miss pulse.
REQ-011 game_over  out  1  level; high while in state OVER.
REQ-012 combo  out  8  consecutive hits since the last miss or start.
REQ-013 lives  out  2  remaining lives.

Function
REQ-014 Each keys bit SHALL pass through a 2-flop synchronizer and then be inverted, giving the pressed level.
REQ-015 Each lane SHALL have an independent debounce counter.
- Debounced state changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any return to agreement clears that lane's counter.
REQ-016 The press vector P[3:0] SHALL be a one-cycle pulse per lane on the 0->1 edge of the debounced state; releases generate nothing.
REQ-017 The FSM SHALL have four states: IDLE, ARMED (no pending tile), WAIT (pending tile held in 4-bit register target), OVER.
REQ-018 IDLE: on enable=1, load lives=LIVES, combo=0, target=0 and go to ARMED.
REQ-019 ARMED: tick with bottom_lane!=0 SHALL load target=bottom_lane and go to WAIT; tick with bottom_lane=0 stays ARMED.
REQ-020 ARMED: P!=0 SHALL be a wrong press and cause a miss event.
REQ-021 WAIT: P==target exactly SHALL cause a hit.
- increment=1 for one cycle.
- combo+1, saturating at 255.
- target=0; go to ARMED.
REQ-022 WAIT: P!=0 and P!=target (wrong lane or multiple lanes) SHALL cause a miss event; target is retained.
REQ-023 WAIT: tick without a hit in the same cycle (tile passed) SHALL cause a miss event, then reload target from bottom_lane per REQ-019.
REQ-024 A press and a tick in the same cycle SHALL be handled as follows.
- The press is judged against the old target first; the tick then loads the new target.
- Both outputs may pulse.
- At most one miss per cycle (one life lost) even when two miss causes coincide.
REQ-025 A miss event SHALL assert miss=1 for one cycle, set combo=0 and decrement lives.
- If lives becomes 0, go to OVER in the same edge; no further increment or miss.
REQ-026 OVER SHALL hold game_over=1 and freeze combo and lives; presses and ticks are ignored.
REQ-027 enable=0 in any state SHALL force IDLE on the next edge and clear increment, miss, game_over and target; combo and lives hold until the next start.
REQ-028 increment and miss SHALL be registered outputs, asserted the cycle after the judging edge inputs are sampled; the latency from the debounced edge to increment is 1 cycle.

Reset
REQ-029 While reset=1, the block SHALL force state=IDLE, increment=0, miss=0, game_over=0, combo=0, lives=0 and target=0.
- Also clears all synchronizer flops to released, all debounced states to released and all debounce counters to 0.
REQ-030 Reset SHALL take effect immediately, independent of clock; on deassertion the block waits in IDLE for enable.
REQ-031 Reset mid-game SHALL discard any pending tile and any in-progress debounce without emitting pulses.

Verification (DEBOUNCE_CYCLES=4, LIVES=3)
REQ-032 Start, then tick with bottom_lane=0100, then hold keys[2]=0 for 6 cycles -> exactly one increment pulse, combo=1, lives=3, state ARMED.
REQ-033 Bounce keys[1] low for 3 cycles, high 1 cycle, low 3 cycles -> no P pulse, no judgement.
REQ-034 Three successive ticks with tiles each left unhit -> miss on the 2nd and 3rd ticks; then a wrong press -> lives=0, game_over=1, combo=0; further ticks produce no pulses.
REQ-035 In WAIT with target=0001, a hit press coincides with tick and bottom_lane=1000 -> increment=1, miss=0, target=1000, state WAIT.
REQ-036 Score combo to 255 then one more hit -> combo stays 255, increment still pulses.
REQ-037 Assert reset mid-debounce while in WAIT -> all outputs 0 at once; after release, enable=1 gives lives=3, and the stale press yields no increment.
